// File: rtl/decimal_timer_n.sv
// Packed-BCD up/down timer with an internal prescaler, stop-with-done or wrap-with-carry
// terminal behaviour, and clear > load > start command priority.
module decimal_timer_n #(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned PRESCALE = 50_000_000,
  parameter int unsigned WRAP     = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  start,
  input  logic                  enable,
  input  logic                  dir,
  input  logic [4*DIGITS-1:0]   limit,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  carry,
  output logic                  done,
  output logic                  running
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PresLast = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    count_q, count_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            tick_q, tick_d;
  logic            carry_q, carry_d;

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
    end
    return r;
  endfunction

  logic [W-1:0] step_up, step_dn;
  logic         up_term, is_zero;

  // Valid BCD orders the same as binary, so plain compares work on the packed value.
  assign step_up = bcd_inc(count_q);
  assign step_dn = bcd_dec(count_q);
  assign up_term = (count_q >= limit);
  assign is_zero = (count_q == '0);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    carry_d = 1'b0;
    if (clear) begin
      count_d = '0;
      presc_d = '0;
      state_d = StIdle;
    end else if (load) begin
      count_d = bcd_clamp(load_value);
      presc_d = '0;
      if (state_q == StDone) state_d = StIdle;
    end else if (start && (state_q == StIdle)) begin
      if ((WRAP == 0) && (dir ? up_term : is_zero)) state_d = StDone;
      else                                          state_d = StRun;
    end else if ((state_q == StRun) && enable) begin
      if (presc_q == PresLast) begin
        presc_d = '0;
        tick_d  = 1'b1;
        if (dir) begin
          if (WRAP != 0) begin
            if (up_term) begin
              count_d = '0;
              carry_d = 1'b1;
            end else begin
              count_d = step_up;
            end
          end else if (up_term || (step_up == limit)) begin
            count_d = limit;
            state_d = StDone;
          end else begin
            count_d = step_up;
          end
        end else begin
          if (WRAP != 0) begin
            if (is_zero) begin
              count_d = limit;
              carry_d = 1'b1;
            end else begin
              count_d = step_dn;
            end
          end else if (is_zero || (step_dn == '0)) begin
            count_d = '0;
            state_d = StDone;
          end else begin
            count_d = step_dn;
          end
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
    end
  end

  assign count   = count_q;
  assign tick    = tick_q;
  assign carry   = carry_q;
  assign done    = (state_q == StDone);
  assign running = (state_q == StRun);

endmodule

// File: tb/tb_decimal_timer_n.sv
// Bench for decimal_timer_n: a WRAP=0 and a WRAP=1 instance share stimulus and are checked
// every cycle against an integer-arithmetic model, plus a vector table and directed sequences.
module tb_decimal_timer_n;

  localparam int unsigned DIGITS   = 2;
  localparam int unsigned PRESCALE = 4;
  localparam int SIdle = 0;
  localparam int SRun  = 1;
  localparam int SDone = 2;

  logic       clock = 1'b0;
  logic       reset, clear, load, start, enable, dir;
  logic [7:0] load_value, limit;
  logic [7:0] count0, count1;
  logic       tick0, tick1, carry0, carry1, done0, done1, running0, running1;

  always #5 clock = ~clock;

  decimal_timer_n #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .WRAP(0)) u0 (
    .clock(clock), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
    .start(start), .enable(enable), .dir(dir), .limit(limit), .count(count0),
    .tick(tick0), .carry(carry0), .done(done0), .running(running0)
  );

  decimal_timer_n #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .WRAP(1)) u1 (
    .clock(clock), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
    .start(start), .enable(enable), .dir(dir), .limit(limit), .count(count1),
    .tick(tick1), .carry(carry1), .done(done1), .running(running1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: count held as a plain integer 0..99, index 0 = WRAP 0, 1 = WRAP 1.
  int m_cnt[2];
  int m_st[2];
  int m_ps[2];
  bit m_tk[2];
  bit m_cy[2];

  function automatic int bcd2int(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic int clamp2int(input logic [7:0] v);
    int hi, lo;
    hi = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
    lo = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
    return hi * 10 + lo;
  endfunction

  function automatic logic [7:0] int2bcd(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_cnt[w] = 0; m_st[w] = SIdle; m_ps[w] = 0; m_tk[w] = 0; m_cy[w] = 0;
    end
  endtask

  task automatic model_edge();
    for (int w = 0; w < 2; w++) begin
      int lim;
      lim = bcd2int(limit);
      m_tk[w] = 0;
      m_cy[w] = 0;
      if (clear) begin
        m_cnt[w] = 0; m_ps[w] = 0; m_st[w] = SIdle;
      end else if (load) begin
        m_cnt[w] = clamp2int(load_value);
        m_ps[w] = 0;
        if (m_st[w] == SDone) m_st[w] = SIdle;
      end else if (start && m_st[w] == SIdle) begin
        if (w == 0 && (dir ? (m_cnt[w] >= lim) : (m_cnt[w] == 0))) m_st[w] = SDone;
        else m_st[w] = SRun;
      end else if (m_st[w] == SRun && enable) begin
        if (m_ps[w] == PRESCALE - 1) begin
          m_ps[w] = 0;
          m_tk[w] = 1;
          if (dir) begin
            if (w == 1) begin
              if (m_cnt[w] >= lim) begin m_cnt[w] = 0; m_cy[w] = 1; end
              else m_cnt[w] = (m_cnt[w] + 1) % 100;
            end else if (m_cnt[w] + 1 >= lim) begin
              m_cnt[w] = lim; m_st[w] = SDone;
            end else m_cnt[w] = m_cnt[w] + 1;
          end else begin
            if (w == 1) begin
              if (m_cnt[w] == 0) begin m_cnt[w] = lim; m_cy[w] = 1; end
              else m_cnt[w] = m_cnt[w] - 1;
            end else if (m_cnt[w] <= 1) begin
              m_cnt[w] = 0; m_st[w] = SDone;
            end else m_cnt[w] = m_cnt[w] - 1;
          end
        end else begin
          m_ps[w] = m_ps[w] + 1;
        end
      end
    end
  endtask

  function automatic logic [11:0] dut_pack(input int w);
    if (w == 0) return {count0, tick0, carry0, done0, running0};
    return {count1, tick1, carry1, done1, running1};
  endfunction

  function automatic logic [11:0] model_pack(input int w);
    return {int2bcd(m_cnt[w]), m_tk[w], m_cy[w], m_st[w] == SDone, m_st[w] == SRun};
  endfunction

  task automatic cycle();
    model_edge();
    @(posedge clock);
    #1;
    check("u0 vs model {count,tick,carry,done,running}", 32'(dut_pack(0)), 32'(model_pack(0)));
    check("u1 vs model {count,tick,carry,done,running}", 32'(dut_pack(1)), 32'(model_pack(1)));
  endtask

  task automatic cmd_idle();
    clear = 0; load = 0; start = 0;
  endtask

  typedef struct {
    logic       clr, ld;
    logic [7:0] lv;
    logic       st, en, dr;
    logic [7:0] lim;
    logic [7:0] e_cnt;
    logic       e_run, e_done;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [7:0] prev;
    bit         seen, ok, done_seen;
    int         carries;

    reset = 1; clear = 0; load = 0; start = 0; enable = 0; dir = 1;
    load_value = 8'h00; limit = 8'h00;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset u0 outputs", 32'(dut_pack(0)), 32'h0);
    check("reset u1 outputs", 32'(dut_pack(1)), 32'h0);
    @(negedge clock);
    reset = 0;

    // WRAP=0 instance expectations for single-cycle commands
    tbl[0]  = '{1'b1, 1'b1, 8'h34, 1'b1, 1'b0, 1'b1, 8'h50, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'h34, 1'b1, 1'b0, 1'b1, 8'h50, 8'h34, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b1, 8'h50, 8'h79, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h50, 8'h79, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h50, 8'h79, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h50, 8'h05, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h50, 8'h05, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h50, 8'h05, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h50, 8'h00, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 8'h50, 8'h93, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 8'h9A, 1'b0, 1'b0, 1'b0, 8'h50, 8'h99, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h99, 8'h99, 1'b0, 1'b1};
    for (int i = 0; i < 12; i++) begin
      clear = tbl[i].clr; load = tbl[i].ld; load_value = tbl[i].lv; start = tbl[i].st;
      enable = tbl[i].en; dir = tbl[i].dr; limit = tbl[i].lim;
      cycle();
      check($sformatf("table row %0d {count,running,done}", i),
            32'({count0, running0, done0}), 32'({tbl[i].e_cnt, tbl[i].e_run, tbl[i].e_done}));
    end
    cmd_idle();

    // Up to limit 12 with WRAP=0, including the 09 -> 10 digit carry
    clear = 1; cycle(); clear = 0;
    dir = 1; limit = 8'h12; enable = 1;
    start = 1; cycle(); start = 0;
    prev = count0; seen = 0;
    for (int i = 0; i < 48; i++) begin
      cycle();
      if (prev == 8'h09 && count0 == 8'h10) seen = 1;
      prev = count0;
    end
    check("up limit count/done/running", 32'({count0, done0, running0}), 32'({8'h12, 2'b10}));
    check("up saw 09->10 step", 32'(seen), 32'd1);
    start = 1; cycle(); start = 0;
    check("start ignored in DONE", 32'({count0, done0, running0}), 32'({8'h12, 2'b10}));

    // Down with wrap to limit 59
    clear = 1; cycle(); clear = 0;
    load = 1; load_value = 8'h10; cycle(); load = 0;
    dir = 0; limit = 8'h59; enable = 1;
    start = 1; cycle(); start = 0;
    carries = 0; ok = 1; done_seen = 0;
    for (int i = 0; i < 44; i++) begin
      cycle();
      if (carry1) begin
        carries++;
        if (count1 != 8'h59) ok = 0;
      end
      if (done1) done_seen = 1;
    end
    check("down wrap carry count", 32'(carries), 32'd1);
    check("down wrap carry only at 59", 32'(ok), 32'd1);
    check("down wrap done never", 32'(done_seen), 32'd0);
    check("down wrap final count", 32'(count1), 32'h59);

    // Pause with the prescaler at 2
    clear = 1; cycle(); clear = 0;
    dir = 1; limit = 8'h99; enable = 1;
    start = 1; cycle(); start = 0;
    cycle(); cycle();
    enable = 0;
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (count0 != 8'h00 || tick0) ok = 0;
    end
    check("pause holds count", 32'(ok), 32'd1);
    enable = 1;
    cycle();
    check("pause no early tick", 32'(tick0), 32'd0);
    cycle();
    check("pause delayed tick", 32'({tick0, count0}), 32'({1'b1, 8'h01}));

    // Clamp, terminal start and wrap-from-above-limit
    clear = 1; cycle(); clear = 0;
    load = 1; load_value = 8'h7F; cycle(); load = 0;
    check("clamp 7F u0", 32'(count0), 32'h79);
    dir = 1; limit = 8'h50; enable = 1;
    start = 1; cycle(); start = 0;
    check("terminal start u0 done", 32'({done0, running0}), 32'b10);
    check("terminal start u1 runs", 32'({done1, running1}), 32'b01);
    repeat (4) cycle();
    check("u1 wrap from above limit", 32'({count1, carry1, tick1}), 32'({8'h00, 2'b11}));

    // Asynchronous reset between edges while running
    clear = 1; cycle(); clear = 0;
    dir = 1; limit = 8'h99; enable = 1;
    start = 1; cycle(); start = 0;
    repeat (4) cycle();
    #2 reset = 1;
    #1;
    check("async reset u0", 32'(dut_pack(0)), 32'h0);
    check("async reset u1", 32'(dut_pack(1)), 32'h0);
    model_reset();
    @(negedge clock);
    reset = 0;
    repeat (3) cycle();
    check("idle after reset", 32'({running0, running1}), 32'b00);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      clear = ($urandom % 50) == 0;
      load = ($urandom % 25) == 0;
      load_value = 8'($urandom);
      start = ($urandom % 6) == 0;
      enable = ($urandom % 8) != 0;
      if (($urandom % 40) == 0) dir = ~dir;
      if (($urandom % 60) == 0) limit = {4'($urandom % 10), 4'($urandom % 10)};
      cycle();
    end
    cmd_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decimal_timer_n.md
# decimal_timer_n

Parametrised BCD timer for the game's global clock and per-round countdowns. It holds DIGITS packed decimal digits and owns an internal prescaler that derives a step tick from the system clock. It counts up toward a programmable limit or down toward zero, and either stops with a done flag or wraps with a carry pulse. It sits between the top-level control FSM (start/clear/load/enable) and the seven-segment decoders, which read the count bus.

## Interface
- DIGITS, 2, number of BCD digits; count width is 4*DIGITS.
- PRESCALE, 50_000_000, clock cycles per step tick; legal range is 1 or more.
- WRAP, 0, 0 = stop at terminal value and assert done; 1 = wrap around and pulse carry.

- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- clear  in  1  sync; count := 0, prescaler := 0, state := IDLE.
- load  in  1  sync; count := clamped load_value, prescaler := 0.
- load_value  in  4*DIGITS  packed BCD value; digit 0 is in bits [3:0].
- start  in  1  sync pulse; IDLE -> RUN.
- enable  in  1  level; 0 pauses the prescaler while in RUN.
- dir  in  1  1 = count up, 0 = count down.
- limit  in  4*DIGITS  packed BCD terminal value for up-counting and the wrap target for down-counting; must be valid BCD.
- count  out  4*DIGITS  registered packed BCD count.
- tick  out  1  one-cycle pulse, asserted in the cycle count shows the new step.
- carry  out  1  one-cycle pulse on a wrap (WRAP=1 only).
- done  out  1  level, high while in DONE.
- running  out  1  level, high while in RUN.

## Operation
- States are IDLE, RUN and DONE.
- Reset sets state to IDLE and count, prescaler, tick, carry and done all to 0.
- Command priority within a cycle is clear > load > start. A lower-priority command asserted in the same cycle as a higher one is dropped.
- load is legal in any state.
  - Each load_value digit above 9 is clamped to 9.
  - The prescaler is zeroed.
  - The state does not change, except that DONE goes to IDLE.
- start is acted on only in IDLE; it is ignored in RUN and DONE.
  - In IDLE with WRAP=0, if count is already terminal, start goes directly to DONE without stepping. Terminal means count >= limit when dir=1, or count == 0 when dir=0.
  - Otherwise start goes to RUN.
- In RUN with enable=1, the prescaler increments each cycle.
- When the prescaler reaches PRESCALE-1, it resets to 0 and one step occurs with tick=1.
- With enable=0 the prescaler holds its value and no step occurs.
- Up step: digit 0 increments. A digit at 9 becomes 0 and carries into the next digit. The top digit at 9 becomes 0.
- Down step: digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit.
- Up, WRAP=0:
  - Stepping from limit-1 reaches limit; state goes to DONE with done=1.
  - If count > limit (after a load), the next step sets count to limit and enters DONE.
- Up, WRAP=1: stepping from count >= limit gives count=0 with carry=1. Otherwise it is a normal increment.
- Down, WRAP=0: stepping to 0 enters DONE.
- Down, WRAP=1: stepping from 0 gives count=limit with carry=1.
- In DONE, count holds and no ticks occur. clear or load exits DONE.
- dir and limit are sampled at each step. A change between steps applies at the next step.
- For PRESCALE=1, a step occurs on every enabled RUN cycle.

## Timing
- All outputs are registered. count, tick and carry update on the same edge.
- start sampled at edge N gives running=1 after edge N.
- The first tick occurs at edge N+PRESCALE, given that enable stays high.
- done rises on the same edge that writes the terminal count, and running falls on that edge.
- clear and load take effect on the next edge. The tick in progress is cancelled.
- An asynchronous reset mid-run forces all outputs to 0 immediately, with no dependence on a clock edge.
- The prescaler width is clog2(PRESCALE), with a minimum of 1.

## Test plan
(DIGITS=2 and PRESCALE=4 unless noted.)
- Up, WRAP=0, limit=0x12: clear, then start. After 12 ticks (48 RUN cycles) count=0x12, done=1 and running=0. The 0x09 -> 0x10 step must be observed. Further start pulses are ignored.
- Down, WRAP=1, limit=0x59: load 0x10, then start. Count runs 0x10, 0x09 … 0x00, 0x59, with carry=1 exactly in the 0x59 cycle and done never asserted.
- Pause: enable=0 for 10 cycles while the prescaler is at 2. The next tick arrives exactly 10 cycles later than nominal, and count is unchanged during the pause.
- Priority: clear, load (0x34) and start asserted in the same cycle give count=0x00 and state IDLE. load+start together give count=0x34 and state IDLE.
- Clamp and terminal: load 0x7F gives count=0x79. With dir=1, limit=0x50 and WRAP=0, start enters DONE immediately. With WRAP=1, the first tick gives count=0x00 and carry=1.
- Reset: assert reset mid-run between clock edges. count, tick, carry, done and running go to 0 before the next edge, and the block stays in IDLE after release.
